// File: rtl/relu_maxpool2x2_stream.sv
// ReLU followed by 2x2/stride-2 max pooling on a raster-order FP32 pixel stream.
// One pooled pixel is emitted one cycle after the bottom-right pixel of each window.
module relu_maxpool2x2_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = 112,
    parameter int unsigned HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned RW  = $clog2(HEIGHT);
    localparam int unsigned LD  = WIDTH / 2;
    localparam int unsigned LAW = (LD > 1) ? $clog2(LD) : 1;

    if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0 || WIDTH < 2 || HEIGHT < 2) begin : g_bad_dims
        $error("relu_maxpool2x2_stream: WIDTH and HEIGHT must be even and >= 2");
    end

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] lb_q [LD];
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] relu_d;
    logic [DATA_WIDTH-1:0] hmax_d;
    logic [DATA_WIDTH-1:0] vmax_d;
    logic [LAW-1:0]        lb_idx;
    logic                  col_last;
    logic                  row_last;
    logic                  accept;

    // Post-ReLU values are non-negative, so the magnitude bits order like unsigned ints.
    function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    endfunction

    always_comb begin
        relu_d   = data_in[DATA_WIDTH-1] ? '0 : data_in;
        hmax_d   = umax(pair_q, relu_d);
        lb_idx   = LAW'(col_q >> 1);
        vmax_d   = umax(lb_q[lb_idx], hmax_d);
        col_last = (col_q == CW'(WIDTH - 1));
        row_last = (row_q == RW'(HEIGHT - 1));
        accept   = valid_in && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (valid_in) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                if (!col_q[0]) begin
                    pair_q <= relu_d;
                end else if (row_q[0]) begin
                    data_q  <= vmax_d;
                    valid_q <= 1'b1;
                    done_q  <= col_last && row_last;
                end
            end
        end
    end

    // Line buffer has no reset; its contents are always rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) begin
            lb_q[lb_idx] <= hmax_d;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign frame_done = done_q;

endmodule
